// File: rtl/branch_resolve.sv
// Branch resolution stage: captures a conditional branch, waits for the condition
// unit, then issues a fetch redirect on mispredict and reports the outcome.
module branch_resolve #(
    parameter int ADDR_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_WIDTH-1:0]  instr_pc,
    input  logic [ADDR_WIDTH-1:0]  offset,
    input  logic                   predicted_taken,
    input  logic                   branch_condition,
    input  logic                   branch_code_legal,
    input  logic                   branch_valid,
    input  logic                   kill,
    output logic                   redirect_valid,
    input  logic                   redirect_ready,
    output logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   result_taken,
    output logic                   result_mispredict,
    output logic                   result_illegal,
    output logic                   result_misaligned,
    output logic [COUNT_WIDTH-1:0] branch_count,
    output logic [COUNT_WIDTH-1:0] mispredict_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESOLVE,
        S_REDIRECT,
        S_REPORT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [ADDR_WIDTH-1:0]  r_offset;
    logic                   r_pred;
    logic [ADDR_WIDTH-1:0]  r_redirect_pc;
    logic                   r_taken;
    logic                   r_mispredict;
    logic                   r_illegal;
    logic                   r_misaligned;
    logic [COUNT_WIDTH-1:0] r_branch_count;
    logic [COUNT_WIDTH-1:0] r_mispredict_count;

    logic [ADDR_WIDTH-1:0]  w_target;
    logic [ADDR_WIDTH-1:0]  w_fallthrough;
    logic [ADDR_WIDTH-1:0]  w_next_pc;
    logic                   w_misaligned;
    logic                   w_mispredict;
    logic                   w_resolving;
    logic                   w_legal_resolve;
    logic                   w_do_redirect;
    logic                   w_clear_flags;

    // Both sums wrap modulo 2^ADDR_WIDTH by construction.
    assign w_target        = r_pc + r_offset;
    assign w_fallthrough   = r_pc + ADDR_WIDTH'(4);
    assign w_next_pc       = branch_condition ? w_target : w_fallthrough;
    assign w_misaligned    = branch_condition && (w_target[1:0] != 2'b00);
    assign w_mispredict    = branch_condition ^ r_pred;

    // An illegal code resolves immediately; kill in the resolving cycle suppresses everything.
    assign w_resolving     = (r_state == S_RESOLVE) && !kill && (!branch_code_legal || branch_valid);
    assign w_legal_resolve = w_resolving && branch_code_legal;
    assign w_do_redirect   = w_legal_resolve && !w_misaligned && w_mispredict;
    assign w_clear_flags   = ((r_state != S_IDLE) && kill) || ((r_state == S_REPORT) && result_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) w_state_next = S_RESOLVE;
            end
            S_RESOLVE: begin
                if (kill)                    w_state_next = S_IDLE;
                else if (!branch_code_legal) w_state_next = S_REPORT;
                else if (branch_valid)       w_state_next = w_do_redirect ? S_REDIRECT : S_REPORT;
            end
            S_REDIRECT: begin
                if (kill)                w_state_next = S_IDLE;
                else if (redirect_ready) w_state_next = S_REPORT;
            end
            S_REPORT: begin
                if (kill || result_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready       = (r_state == S_IDLE);
        redirect_valid = (r_state == S_REDIRECT);
        result_valid   = (r_state == S_REPORT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc               <= '0;
            r_offset           <= '0;
            r_pred             <= 1'b0;
            r_redirect_pc      <= '0;
            r_taken            <= 1'b0;
            r_mispredict       <= 1'b0;
            r_illegal          <= 1'b0;
            r_misaligned       <= 1'b0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if ((r_state == S_IDLE) && in_valid) begin
                r_pc     <= instr_pc;
                r_offset <= offset;
                r_pred   <= predicted_taken;
            end
            // Flags are latched at resolution and stay put through any redirect.
            if (w_resolving) begin
                r_illegal    <= !branch_code_legal;
                r_taken      <= branch_code_legal && branch_condition;
                r_mispredict <= branch_code_legal && w_mispredict;
                r_misaligned <= branch_code_legal && w_misaligned;
            end else if (w_clear_flags) begin
                r_illegal    <= 1'b0;
                r_taken      <= 1'b0;
                r_mispredict <= 1'b0;
                r_misaligned <= 1'b0;
            end
            if (w_do_redirect) begin
                r_redirect_pc <= w_next_pc;
            end
            if (w_legal_resolve && (r_branch_count != {COUNT_WIDTH{1'b1}})) begin
                r_branch_count <= r_branch_count + COUNT_WIDTH'(1);
            end
            if (w_do_redirect && (r_mispredict_count != {COUNT_WIDTH{1'b1}})) begin
                r_mispredict_count <= r_mispredict_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign redirect_pc       = r_redirect_pc;
    assign result_taken      = r_taken;
    assign result_mispredict = r_mispredict;
    assign result_illegal    = r_illegal;
    assign result_misaligned = r_misaligned;
    assign branch_count      = r_branch_count;
    assign mispredict_count  = r_mispredict_count;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: transaction-level reference model,
// per-cycle compare process, directed corner cases and randomized traffic.
module tb_branch_resolve;

    localparam int AW   = 32;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] instr_pc;
    logic [AW-1:0] offset;
    logic          predicted_taken;
    logic          branch_condition;
    logic          branch_code_legal;
    logic          branch_valid;
    logic          kill;
    logic          redirect_valid;
    logic          redirect_ready;
    logic [AW-1:0] redirect_pc;
    logic          result_valid;
    logic          result_ready;
    logic          result_taken;
    logic          result_mispredict;
    logic          result_illegal;
    logic          result_misaligned;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    branch_resolve #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .instr_pc          (instr_pc),
        .offset            (offset),
        .predicted_taken   (predicted_taken),
        .branch_condition  (branch_condition),
        .branch_code_legal (branch_code_legal),
        .branch_valid      (branch_valid),
        .kill              (kill),
        .redirect_valid    (redirect_valid),
        .redirect_ready    (redirect_ready),
        .redirect_pc       (redirect_pc),
        .result_valid      (result_valid),
        .result_ready      (result_ready),
        .result_taken      (result_taken),
        .result_mispredict (result_mispredict),
        .result_illegal    (result_illegal),
        .result_misaligned (result_misaligned),
        .branch_count      (branch_count),
        .mispredict_count  (mispredict_count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Model expectations for the current cycle
    logic          chk_en = 1'b0;
    logic          exp_in_ready, exp_rv, exp_resv;
    logic [AW-1:0] exp_rpc;
    logic          exp_ft, exp_fmp, exp_fill, exp_fmis;
    int            exp_bc, exp_mc;

    // Values seen right after the resolving edge of the last branch
    logic          cap_rv, cap_resv, cap_mis, cap_ill;
    logic [AW-1:0] cap_rpc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("in_ready", 32'(in_ready), 32'(exp_in_ready));
            check("redirect_valid", 32'(redirect_valid), 32'(exp_rv));
            check("result_valid", 32'(result_valid), 32'(exp_resv));
            if (exp_rv) check("redirect_pc", redirect_pc, exp_rpc);
            if (exp_resv || exp_in_ready) begin
                check("result_taken", 32'(result_taken), 32'(exp_ft));
                check("result_mispredict", 32'(result_mispredict), 32'(exp_fmp));
                check("result_illegal", 32'(result_illegal), 32'(exp_fill));
                check("result_misaligned", 32'(result_misaligned), 32'(exp_fmis));
            end
            check("branch_count", 32'(branch_count), 32'(exp_bc));
            check("mispredict_count", 32'(mispredict_count), 32'(exp_mc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        in_valid        = 1'($urandom);
        instr_pc        = $urandom;
        offset          = $urandom;
        predicted_taken = 1'($urandom);
    endtask

    task automatic go_idle();
        exp_in_ready = 1'b1;
        exp_rv       = 1'b0;
        exp_resv     = 1'b0;
        exp_ft       = 1'b0;
        exp_fmp      = 1'b0;
        exp_fill     = 1'b0;
        exp_fmis     = 1'b0;
        in_valid       = 1'b0;
        kill           = 1'b0;
        redirect_ready = 1'b0;
        result_ready   = 1'b0;
    endtask

    // ks: 0 none, 1 kill while waiting for branch_valid, 2 kill in resolving cycle,
    // 3 kill with redirect_ready, 4 kill with result_ready, 5 kill in IDLE at accept,
    // 6 leave the branch sitting in REPORT.
    task automatic do_branch(input logic [31:0] pc, input logic [31:0] off, input logic pred,
                             input logic cond, input logic legal, input int vd, input int rw,
                             input int qw, input int ks);
        logic [31:0] tgt, nxt;
        logic        mis, mp, redir;
        tgt   = pc + off;
        nxt   = cond ? tgt : pc + 32'd4;
        mis   = cond && (tgt[1:0] != 2'b00);
        mp    = cond ^ pred;
        redir = legal && !mis && mp;
        cap_rv = 1'b0; cap_resv = 1'b0; cap_mis = 1'b0; cap_ill = 1'b0; cap_rpc = '0;

        in_valid = 1'b1; instr_pc = pc; offset = off; predicted_taken = pred;
        branch_code_legal = legal; branch_valid = 1'b0; branch_condition = 1'($urandom);
        kill = (ks == 5); redirect_ready = 1'($urandom); result_ready = 1'($urandom);
        tick();
        exp_in_ready = 1'b0;
        kill = 1'b0;
        noise();
        if (ks == 1 && legal) begin
            kill = 1'b1;
            tick();
            go_idle();
            return;
        end
        if (legal) begin
            repeat (vd) begin
                redirect_ready = 1'($urandom); result_ready = 1'($urandom);
                tick();
                noise();
                branch_condition = 1'($urandom);
            end
            branch_valid = 1'b1;
            branch_condition = cond;
        end
        kill = (ks == 2);
        tick();
        branch_valid = 1'b0;
        branch_condition = 1'($urandom);
        if (ks == 2) begin
            go_idle();
            return;
        end
        if (legal) begin
            exp_bc = sat(exp_bc + 1);
            if (redir) exp_mc = sat(exp_mc + 1);
        end
        exp_ft   = legal && cond;
        exp_fmp  = legal && mp;
        exp_fill = !legal;
        exp_fmis = legal && mis;
        cap_rv = redirect_valid; cap_rpc = redirect_pc; cap_resv = result_valid;
        cap_mis = result_misaligned; cap_ill = result_illegal;
        noise();
        if (redir) begin
            exp_rv  = 1'b1;
            exp_rpc = nxt;
            repeat (rw) begin
                redirect_ready = 1'b0; result_ready = 1'($urandom);
                tick();
                noise();
            end
            redirect_ready = 1'b1; result_ready = 1'($urandom);
            kill = (ks == 3);
            tick();
            if (ks == 3) begin
                go_idle();
                return;
            end
            redirect_ready = 1'b0;
            exp_rv   = 1'b0;
            exp_resv = 1'b1;
            noise();
        end else begin
            exp_resv = 1'b1;
        end
        repeat (qw) begin
            result_ready = 1'b0; redirect_ready = 1'($urandom);
            tick();
            noise();
        end
        if (ks == 6) begin
            in_valid = 1'b0; result_ready = 1'b0; redirect_ready = 1'b0;
            return;
        end
        result_ready = 1'b1;
        kill = (ks == 4);
        tick();
        go_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, fails so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        go_idle();
        instr_pc = '0; offset = '0; predicted_taken = 1'b0;
        branch_condition = 1'b0; branch_code_legal = 1'b1; branch_valid = 1'b0;
        exp_rpc = '0; exp_bc = 0; exp_mc = 0;
        #1;
        check("reset redirect_valid", 32'(redirect_valid), 32'd0);
        check("reset result_valid", 32'(result_valid), 32'd0);
        check("reset redirect_pc", redirect_pc, 32'd0);
        check("reset branch_count", 32'(branch_count), 32'd0);
        tick();
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        // Not taken, correctly predicted
        do_branch(32'h100, 32'h20, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        check("tp1 result_valid at N+2", 32'(cap_resv), 32'd1);
        check("tp1 no redirect", 32'(cap_rv), 32'd0);
        check("tp1 branch_count", 32'(branch_count), 32'd1);
        // Taken, mispredicted, redirect held three cycles
        do_branch(32'h100, 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b1, 0, 3, 0, 0);
        check("tp2 redirect_valid", 32'(cap_rv), 32'd1);
        check("tp2 redirect_pc", cap_rpc, 32'h0000_00F0);
        check("tp2 mispredict_count", 32'(mispredict_count), 32'd1);
        // Predicted taken, not taken, fallthrough wraps
        do_branch(32'hFFFF_FFFC, 32'h40, 1'b1, 1'b0, 1'b1, 1, 1, 1, 0);
        check("tp3 redirect_valid", 32'(cap_rv), 32'd1);
        check("tp3 redirect_pc wrap", cap_rpc, 32'h0000_0000);
        // Misaligned taken target
        do_branch(32'h200, 32'h6, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
        check("tp4 misaligned", 32'(cap_mis), 32'd1);
        check("tp4 no redirect", 32'(cap_rv), 32'd0);
        check("tp4 mispredict_count", 32'(mispredict_count), 32'd2);
        check("tp4 branch_count", 32'(branch_count), 32'd4);
        // Illegal funct3 with branch_valid low
        do_branch(32'h300, 32'h8, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        check("tp5 illegal", 32'(cap_ill), 32'd1);
        check("tp5 result_valid at N+2", 32'(cap_resv), 32'd1);
        check("tp5 branch_count", 32'(branch_count), 32'd4);
        // Kill in REDIRECT together with redirect_ready
        do_branch(32'h100, 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b1, 0, 1, 0, 3);
        check("tp6 result_valid after kill", 32'(result_valid), 32'd0);
        check("tp6 mispredict_count kept", 32'(mispredict_count), 32'd3);
        // Kill in the resolving cycle, then kill in IDLE with in_valid
        do_branch(32'h100, 32'h8, 1'b1, 1'b0, 1'b1, 1, 0, 0, 2);
        check("tp7 branch_count", 32'(branch_count), 32'd5);
        do_branch(32'h400, 32'h10, 1'b1, 1'b1, 1'b1, 0, 0, 0, 5);
        check("tp8 branch_count", 32'(branch_count), 32'd6);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] pc, off;
            int          r, ks, soff;
            pc = $urandom;
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            soff = int'($urandom_range(0, 255)) - 128;
            off  = ($urandom_range(0, 3) == 0) ? $urandom : 32'(soff);
            r    = int'($urandom_range(0, 14));
            ks   = (r < 10) ? 0 : r - 9;
            do_branch(pc, off, 1'($urandom), 1'($urandom), ($urandom_range(0, 9) != 0),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)), ks);
        end

        for (int i = 0; i < 260; i++) begin
            logic [31:0] pc;
            pc = $urandom & 32'hFFFF_FFFC;
            do_branch(pc, 32'h8, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
        end
        check("sat branch_count", 32'(branch_count), 32'h0000_00FF);
        check("sat mispredict_count", 32'(mispredict_count), 32'h0000_00FF);

        // Async reset while a result is pending in REPORT
        do_branch(32'h500, 32'h10, 1'b1, 1'b1, 1'b1, 0, 0, 1, 6);
        check("rst pre result_valid", 32'(result_valid), 32'd1);
        check("rst pre result_taken", 32'(result_taken), 32'd1);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("rst result_valid", 32'(result_valid), 32'd0);
        check("rst redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst result_taken", 32'(result_taken), 32'd0);
        check("rst redirect_pc", redirect_pc, 32'd0);
        check("rst branch_count", 32'(branch_count), 32'd0);
        check("rst mispredict_count", 32'(mispredict_count), 32'd0);
        tick();
        rst_n = 1'b1;
        go_idle();
        exp_bc = 0;
        exp_mc = 0;
        chk_en = 1'b1;
        tick();
        do_branch(32'h600, 32'h20, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
        check("post-rst branch_count", 32'(branch_count), 32'd1);
        check("post-rst redirect_pc", cap_rpc, 32'h0000_0620);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Branch resolution stage directly downstream of the branch-condition unit.
- Captures a conditional-branch instruction's PC, sign-extended B-type offset and fetch prediction.
- Waits for the condition unit to report a valid result, computes the actual next PC, and issues a held fetch redirect on mispredict.
- Reports the resolved outcome to the retire/trap logic and keeps saturating branch/mispredict counters.

Parameters:
- ADDR_WIDTH, 32, width of PC, offset and redirect target.
- COUNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  issuer presents a branch.
- in_ready  output  1  block can accept a branch.
- instr_pc  input  ADDR_WIDTH  PC of the branch.
- offset  input  ADDR_WIDTH  sign-extended B-immediate.
- predicted_taken  input  1  fetch-stage prediction.
- branch_condition  input  1  comparison result from the condition unit.
- branch_code_legal  input  1  funct3 is a legal branch code.
- branch_valid  input  1  condition result is valid.
- kill  input  1  synchronous abandon of the in-flight branch.
- redirect_valid  output  1  fetch redirect request.
- redirect_ready  input  1  fetch accepts the redirect.
- redirect_pc  output  ADDR_WIDTH  corrected next PC.
- result_valid  output  1  outcome available.
- result_ready  input  1  consumer accepts the outcome.
- result_taken  output  1  branch was taken.
- result_mispredict  output  1  result_taken differs from the prediction.
- result_illegal  output  1  illegal funct3.
- result_misaligned  output  1  taken target not 4-byte aligned.
- branch_count  output  COUNT_WIDTH  branches resolved.
- mispredict_count  output  COUNT_WIDTH  mispredicts resolved.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - redirect_valid=0, result_valid=0.
  - redirect_pc=0, all result_* flags=0, both counters=0.
  - in_ready is 1 as soon as reset deasserts.
  - Reset asserted mid-operation discards the branch immediately; no redirect or result survives.
- FSM states: IDLE, RESOLVE, REDIRECT, REPORT. in_ready=1 only in IDLE.
- IDLE:
  - On in_valid&&in_ready, register instr_pc, offset and predicted_taken, then go to RESOLVE.
- Operand stability: the issuer holds the condition unit's operands and funct3 stable from acceptance until the result handshake.
- RESOLVE, evaluated every cycle:
  - branch_code_legal=0: result_illegal=1, taken=0, mispredict=0, no redirect; go to REPORT.
  - Else if branch_valid=1:
    - taken = branch_condition.
    - target = pc+offset, truncated modulo 2^ADDR_WIDTH (wraps).
    - fallthrough = pc+4, also wrapping.
    - next = taken ? target : fallthrough.
    - misaligned = taken && target[1:0]!=0.
    - mispredict = taken ^ predicted_taken.
    - If misaligned: result_misaligned=1 and no redirect, regardless of mispredict; go to REPORT.
    - Else if mispredict: register redirect_pc=next and go to REDIRECT.
    - Else go to REPORT.
  - Else stay in RESOLVE, with no timeout.
- Counters:
  - branch_count increments on every legal resolution, including misaligned ones.
  - mispredict_count increments when mispredict=1 and not misaligned.
  - Both update in the resolving cycle and saturate at all-ones.
  - Illegal resolutions increment neither counter.
- REDIRECT:
  - redirect_valid=1; redirect_pc is held stable until redirect_ready.
  - On redirect_ready, go to REPORT; redirect_valid drops the next cycle.
- REPORT:
  - result_valid=1 with result_* flags held stable until result_ready.
  - On result_ready, clear the flags and go to IDLE.
  - in_ready=1 on the following cycle; there is no same-cycle turnaround.
- Latency: accept at cycle N; if branch_valid=1 at N+1, then:
  - No redirect: result_valid rises at N+2.
  - Redirect: redirect_valid rises at N+2, and result_valid rises the cycle after redirect_ready.
- kill:
  - In RESOLVE, REDIRECT or REPORT: go to IDLE the next cycle, deassert redirect_valid and result_valid, and clear flags.
  - Counter updates already made stay.
  - kill in the resolving cycle wins: no counter update.
  - kill with redirect_ready or result_ready in the same cycle also wins: the handshake is treated as not completed.
  - kill in IDLE has no effect; kill in IDLE with in_valid still accepts the branch.
- Only one branch is in flight at a time.

Test Plan:
- Not-taken, correctly predicted: pc=0x100, off=0x20, pred=0, cond=0, valid at N+1 -> no redirect; result_valid at N+2 with taken=0, mispredict=0; branch_count=1.
- Taken, mispredicted: pc=0x100, off=0xFFFFFFF0, pred=0, cond=1 -> redirect_pc=0xF0; hold redirect_ready=0 for 3 cycles and check redirect_pc is stable; result has mispredict=1; mispredict_count=1.
- Predicted taken, actually not taken: pc=0xFFFFFFFC, pred=1, cond=0 -> redirect_pc=0x00000000 (wrap).
- Misaligned target: pc=0x200, off=0x6, cond=1, pred=0 -> result_misaligned=1, no redirect_valid, mispredict_count unchanged.
- Illegal funct3: branch_code_legal=0 with branch_valid=0 -> result_illegal=1 at N+2; counters unchanged.
- Kill and reset:
  - kill during REDIRECT with redirect_ready=1 -> IDLE next cycle, no result_valid.
  - Preload counters at 0xFFFF and mispredict -> counter stays 0xFFFF.
  - Assert rst_n=0 in REPORT -> all outputs 0 immediately.
